// File: rtl/updn_sweep_ctrl.sv
// Sequencer driving an 8-bit up/down counter through a triangle sweep lo..hi for a set number of legs.
// A shadow copy of the counter is stepped alongside it; any divergence while busy latches sync_err and stops the run.
module updn_sweep_ctrl #(
  parameter int WIDTH  = 8,
  parameter int PASS_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [PASS_W-1:0] passes,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              sync_err,
  output logic [PASS_W-1:0] legs,
  input  logic [WIDTH-1:0]  cnt_value,
  output logic              cnt_reset,
  output logic              cnt_reverse,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    APPROACH = 2'd1,
    UP       = 2'd2,
    DOWN     = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0]  ONE_W = 1;
  localparam logic [PASS_W-1:0] ONE_P = 1;

  state_e              state_q;
  logic [WIDTH-1:0]    lo_q, hi_q, shadow_q;
  logic [PASS_W-1:0]   passes_q, legs_q;
  logic                ready_q, busy_q, done_q, cfg_err_q, sync_err_q;
  logic                cnt_reset_q, cnt_reverse_q;

  logic                accept, cfg_bad, diverged;
  logic [WIDTH-1:0]    lo_e, hi_e, step_v, v_next;
  logic [PASS_W-1:0]   legs_e, passes_e;
  state_e              ph_in;
  state_e              plan_state;
  logic [PASS_W-1:0]   plan_legs;
  logic                plan_rev, plan_rst, plan_done, leg_end;

  assign ready       = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign sync_err    = sync_err_q;
  assign legs        = legs_q;
  assign cnt_reset   = cnt_reset_q;
  assign cnt_reverse = cnt_reverse_q;
  assign dbg_state   = state_q;

  // Plan the controls for the next cycle from the value the counter will hold in it,
  // so the reverse/reset decision is already in place during an endpoint cycle.
  always_comb begin
    accept   = ready_q & start;
    cfg_bad  = (lo >= hi) || (passes == '0);
    diverged = (cnt_value != shadow_q);
    lo_e     = accept ? lo : lo_q;
    hi_e     = accept ? hi : hi_q;
    passes_e = accept ? passes : passes_q;
    legs_e   = accept ? '0 : legs_q;
    ph_in    = accept ? APPROACH : state_q;

    if (cnt_reset_q) step_v = cnt_reverse_q ? '1 : '0;
    else             step_v = cnt_reverse_q ? (shadow_q - ONE_W) : (shadow_q + ONE_W);
    v_next = accept ? '0 : step_v;

    plan_state = ph_in;
    plan_legs  = legs_e;
    plan_rev   = 1'b0;
    plan_rst   = 1'b0;
    plan_done  = 1'b0;
    leg_end    = 1'b0;
    case (ph_in)
      APPROACH: begin
        if (v_next == lo_e) plan_state = UP;
      end
      UP: begin
        if (v_next == hi_e) begin
          leg_end    = 1'b1;
          plan_state = DOWN;
          plan_rev   = 1'b1;
        end
      end
      DOWN: begin
        plan_rev = 1'b1;
        if (v_next == lo_e) begin
          leg_end    = 1'b1;
          plan_state = UP;
          plan_rev   = 1'b0;
        end
      end
      default: ;
    endcase

    if (leg_end) begin
      plan_legs = legs_e + ONE_P;
      if (plan_legs == passes_e) begin
        plan_done = 1'b1;
        plan_rst  = 1'b1;
        plan_rev  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      lo_q          <= '0;
      hi_q          <= '0;
      passes_q      <= '0;
      shadow_q      <= '0;
      legs_q        <= '0;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      sync_err_q    <= 1'b0;
      cnt_reset_q   <= 1'b1;
      cnt_reverse_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (ready_q) begin
        if (accept) begin
          if (cfg_bad) begin
            cfg_err_q <= 1'b1;
          end else begin
            lo_q          <= lo;
            hi_q          <= hi;
            passes_q      <= passes;
            shadow_q      <= '0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= plan_state;
            legs_q        <= plan_legs;
            cnt_reset_q   <= plan_rst;
            cnt_reverse_q <= plan_rev;
            done_q        <= plan_done;
          end
        end
      end else if (diverged || abort || done_q) begin
        // Divergence, abort and the final endpoint cycle all park the counter at zero.
        if (diverged) sync_err_q <= 1'b1;
        state_q       <= IDLE;
        ready_q       <= 1'b1;
        busy_q        <= 1'b0;
        cnt_reset_q   <= 1'b1;
        cnt_reverse_q <= 1'b0;
      end else begin
        shadow_q      <= v_next;
        state_q       <= plan_state;
        legs_q        <= plan_legs;
        cnt_reset_q   <= plan_rst;
        cnt_reverse_q <= plan_rev;
        done_q        <= plan_done;
      end
    end
  end

endmodule

// File: tb/tb_updn_sweep_ctrl.sv
// Bench for updn_sweep_ctrl: a behavioural counter plus a trajectory-based reference model,
// directed scenarios with literal expectations and a randomized run phase.
module tb_updn_sweep_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] lo = '0, hi = '0;
  logic [3:0] passes = '0;
  logic       ready, busy, done, cfg_err, sync_err;
  logic [3:0] legs;
  logic [7:0] cnt_value;
  logic       cnt_reset, cnt_reverse;
  logic [1:0] dbg_state;
  logic       glitch = 1'b0;
  logic [7:0] cnt_q = 8'h5A;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  always #5 clock = ~clock;

  updn_sweep_ctrl #(.WIDTH(8), .PASS_W(4)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .lo(lo), .hi(hi), .passes(passes),
    .ready(ready), .busy(busy), .done(done), .cfg_err(cfg_err), .sync_err(sync_err),
    .legs(legs), .cnt_value(cnt_value), .cnt_reset(cnt_reset), .cnt_reverse(cnt_reverse),
    .dbg_state(dbg_state)
  );

  // The counted block: reset loads 0x00/0xFF, otherwise steps every clock; glitch adds a stray +1.
  assign cnt_value = cnt_q;
  always @(posedge clock) begin
    if (cnt_reset) cnt_q <= (cnt_reverse ? 8'hFF : 8'h00) + {7'd0, glitch};
    else           cnt_q <= (cnt_reverse ? cnt_q - 8'd1 : cnt_q + 8'd1) + {7'd0, glitch};
  end

  // Reference model: a run is the list of counter values from the accept onward, with legs per cycle.
  int  traj[$];
  int  legs_at[$];
  int  idx = -1;
  int  m_legs = 0;
  bit  m_cfg = 0, m_sync = 0, m_known = 0, m_gl = 0;
  int  m_idle_val = 0;

  function automatic void build(int l, int h, int p);
    int v;
    bit up;
    int tgt;
    traj.delete();
    legs_at.delete();
    v = 0;
    traj.push_back(0);
    legs_at.push_back(0);
    while (v < l) begin
      v++;
      traj.push_back(v);
      legs_at.push_back(0);
    end
    up = 1;
    for (int leg = 1; leg <= p; leg++) begin
      tgt = up ? h : l;
      while (v != tgt) begin
        v = up ? v + 1 : v - 1;
        traj.push_back(v);
        legs_at.push_back((v == tgt) ? leg : leg - 1);
      end
      up = !up;
    end
  endfunction

  always @(posedge clock) begin
    int last;
    m_cfg = 0;
    m_gl  = 0;
    if (reset) begin
      idx = -1; m_legs = 0; m_sync = 0; m_known = 0; m_idle_val = 0;
    end else if (idx < 0) begin
      m_known = 1; m_idle_val = 0;
      if (start) begin
        if (lo >= hi || passes == 0) m_cfg = 1;
        else begin
          build(int'(lo), int'(hi), int'(passes));
          idx = 0;
        end
      end
    end else begin
      last = traj.size() - 1;
      if (int'(cnt_q) != traj[idx] || abort || idx == last) begin
        if (int'(cnt_q) != traj[idx]) m_sync = 1;
        m_legs = legs_at[idx];
        m_idle_val = (idx == last) ? 0 : int'(8'(int'(cnt_q) + traj[idx+1] - traj[idx]));
        m_known = 1;
        idx = -1;
      end else begin
        idx++;
        m_gl = glitch;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  int log_v[$];
  int log_l[$];
  int log_d[$];
  bit log_en = 0;

  always @(negedge clock) begin
    int last;
    if (chk_en) begin
      vectors++;
      if (idx >= 0) begin
        last = traj.size() - 1;
        chk("ready", ready, 0);
        chk("busy", busy, 1);
        chk("done", done, idx == last);
        chk("cnt_reset", cnt_reset, idx == last);
        chk("cnt_reverse", cnt_reverse, (idx != last) && (traj[idx+1] < traj[idx]));
        chk("legs", legs, legs_at[idx]);
        chk("cnt_value", cnt_value, 32'(traj[idx] + m_gl));
      end else begin
        chk("ready", ready, 1);
        chk("busy", busy, 0);
        chk("done", done, 0);
        chk("cnt_reset", cnt_reset, 1);
        chk("cnt_reverse", cnt_reverse, 0);
        chk("legs", legs, m_legs);
        if (m_known) chk("cnt_value", cnt_value, m_idle_val);
      end
      chk("cfg_err", cfg_err, m_cfg);
      chk("sync_err", sync_err, m_sync);
      if (log_en && busy === 1'b1) begin
        log_v.push_back(int'(cnt_value));
        log_l.push_back(int'(legs));
        log_d.push_back(int'(done));
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic go(input int l, input int h, input int p, input bit ab);
    lo = 8'(l); hi = 8'(h); passes = 4'(p); start = 1; abort = ab;
    tick();
    start = 0; abort = 0;
  endtask

  task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    chk(n, a, e);
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (ready !== 1'b1 && n < budget) begin tick(); n++; end
    lit("wait_ready_timeout", ready, 1);
  endtask

  task automatic wait_value(input int v, input int budget);
    int n = 0;
    while (int'(cnt_value) != v && n < budget) begin tick(); n++; end
    lit("wait_value_timeout", cnt_value, v);
  endtask

  initial begin
    int t2_v[12] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 3, 4, 5};
    int t2_l[12] = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3};
    repeat (3) tick();
    chk_en = 1;
    tick();
    reset = 0;

    // Idle after reset: counter pinned at zero, no pulses.
    repeat (5) tick();
    lit("t1_value", cnt_value, 8'h00);
    lit("t1_rst", cnt_reset, 1);
    lit("t1_rev", cnt_reverse, 0);
    lit("t1_ready", ready, 1);
    lit("t1_done", done, 0);

    // Three-leg sweep 2..5.
    log_v.delete(); log_l.delete(); log_d.delete();
    log_en = 1;
    go(2, 5, 3, 0);
    wait_ready(100);
    log_en = 0;
    lit("t2_len", log_v.size(), 12);
    for (int i = 0; i < 12 && i < log_v.size(); i++) begin
      lit("t2_val", log_v[i], t2_v[i]);
      lit("t2_legs", log_l[i], t2_l[i]);
      lit("t2_done", log_d[i], (i == 11));
    end
    lit("t2_park", cnt_value, 8'h00);

    // Full-range sweep, must turn at 0xFF without wrapping.
    log_v.delete(); log_l.delete(); log_d.delete();
    log_en = 1;
    go(0, 255, 2, 0);
    wait_ready(600);
    log_en = 0;
    lit("t3_len", log_v.size(), 511);
    if (log_v.size() == 511) begin
      lit("t3_peak", log_v[255], 255);
      lit("t3_turn", log_v[256], 254);
      lit("t3_end", log_v[510], 0);
      lit("t3_done", log_d[510], 1);
    end
    lit("t3_sync", sync_err, 0);

    // Rejected configurations.
    go(5, 5, 1, 0);
    lit("t4_cfg_a", cfg_err, 1);
    lit("t4_ready_a", ready, 1);
    tick();
    lit("t4_cfg_clr", cfg_err, 0);
    go(1, 4, 0, 0);
    lit("t4_cfg_b", cfg_err, 1);
    lit("t4_rst", cnt_reset, 1);
    tick();

    // Abort while rising; a start in the middle of the run is ignored.
    go(2, 9, 4, 0);
    wait_value(4, 20);
    lo = 8'd0; hi = 8'd3; passes = 4'd1; start = 1;
    tick();
    start = 0;
    wait_value(6, 20);
    abort = 1;
    tick();
    abort = 0;
    lit("t5_step", cnt_value, 8'd7);
    lit("t5_ready", ready, 1);
    tick();
    lit("t5_park", cnt_value, 8'd0);
    lit("t5_legs", legs, 0);
    lit("t5_done", done, 0);
    tick();

    // Counter glitch: sticky sync_err, run stops, reset clears it.
    go(1, 20, 3, 0);
    wait_value(10, 30);
    glitch = 1;
    tick();
    glitch = 0;
    lit("t6_glitched", cnt_value, 8'd12);
    tick();
    lit("t6_sync", sync_err, 1);
    lit("t6_ready", ready, 1);
    go(1, 3, 1, 0);
    wait_ready(20);
    lit("t6_sticky", sync_err, 1);
    reset = 1;
    tick();
    reset = 0;
    lit("t6_cleared", sync_err, 0);
    tick();

    // Randomized runs with stray starts, aborts and occasional resets.
    for (int r = 0; r < 30; r++) begin
      int l, h, p, n;
      l = $urandom_range(0, 40);
      h = ($urandom_range(0, 7) == 0) ? l : l + $urandom_range(1, 30);
      p = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
      go(l, h, p, $urandom_range(0, 3) == 0);
      n = 0;
      while (ready !== 1'b1 && n < 400) begin
        if ($urandom_range(0, 59) == 0) abort = 1;
        if ($urandom_range(0, 19) == 0) begin
          lo = 8'($urandom_range(0, 40)); hi = 8'($urandom_range(41, 80));
          passes = 4'($urandom_range(1, 3)); start = 1;
        end
        if ($urandom_range(0, 149) == 0) reset = 1;
        tick();
        abort = 0; start = 0; reset = 0;
        n++;
      end
      lit("rand_timeout", ready, 1);
      repeat ($urandom_range(0, 3)) begin
        abort = ($urandom_range(0, 1) == 1);
        tick();
        abort = 0;
      end
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
